// File: rtl/ysyx_23060208_ifu_fetch.sv
// ysyx_23060208_ifu_fetch: instruction-fetch master for the isram read channel, one read in flight,
// delivering instructions to the IDU and dropping responses cancelled by a redirect.
module ysyx_23060208_ifu_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] isram_araddr,
  output logic                  isram_arvalid,
  input  logic                  isram_arready,
  input  logic                  isram_rvalid,
  input  logic [1:0]            isram_rresp,
  input  logic [DATA_WIDTH-1:0] isram_rdata,
  output logic                  isram_rready,
  input  logic                  idu_allowin,
  output logic                  ifu_to_idu_valid,
  output logic [DATA_WIDTH-1:0] ifu_to_idu_pc,
  output logic [DATA_WIDTH-1:0] ifu_to_idu_inst,
  output logic                  ifu_to_idu_err,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, AR, R, OUT} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] pc, pc_n, addr;
  logic drop, drop_n, hs_r, take;
  always_comb begin
    hs_r = state == R && isram_rvalid;
    take = hs_r && !drop && !redirect_valid;
    pc_n = redirect_valid ? {redirect_pc[DATA_WIDTH-1:2], 2'b00} :
           (state == OUT && idu_allowin) ? pc + DATA_WIDTH'(4) : pc;
    // drop marks the single in-flight response that a redirect has made stale
    drop_n = hs_r ? 1'b0 : (state == AR || state == R) ? drop | redirect_valid : drop;
    state_n = state;
    case (state)
      IDLE: state_n = AR;
      AR:   state_n = isram_arready ? R : AR;
      R:    state_n = hs_r ? (take ? OUT : AR) : R;
      OUT:  state_n = (redirect_valid || idu_allowin) ? AR : OUT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      addr <= RESET_PC;
      drop <= 1'b0;
      ifu_to_idu_pc <= RESET_PC;
      ifu_to_idu_inst <= '0;
      ifu_to_idu_err <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      // the request address is frozen while a request is being offered
      addr <= (state == AR) ? addr : pc_n;
      drop <= drop_n;
      if (take) begin
        ifu_to_idu_pc <= pc;
        ifu_to_idu_inst <= isram_rdata;
        ifu_to_idu_err <= isram_rresp != 2'b00;
      end
    end
  end
  assign isram_araddr = addr;
  assign isram_arvalid = state == AR;
  assign isram_rready = state == R;
  assign ifu_to_idu_valid = state == OUT;
endmodule
